// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core/fetcher state encodings and width constants
package gpu_pkg;

    localparam int PC_BITS       = 8;
    localparam int INSTR_BITS    = 16;
    localparam int WATCHDOG_BITS = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/fetch_reuse_buf.sv
// rtl/fetch_reuse_buf.sv - one-entry last-fetch buffer with hit compare and flush priority
module fetch_reuse_buf #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter bit REUSE_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    input  logic                 fill,
    input  logic [ADDR_BITS-1:0] fill_pc,
    input  logic [DATA_BITS-1:0] fill_data,
    output logic                 hit,
    output logic [DATA_BITS-1:0] hit_data
);

    logic                 buf_valid;
    logic [ADDR_BITS-1:0] buf_pc;
    logic [DATA_BITS-1:0] buf_data;

    // Flush is written last so it overrides a same-cycle fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_data  <= '0;
        end else begin
            if (REUSE_EN && fill) begin
                buf_valid <= 1'b1;
                buf_pc    <= fill_pc;
                buf_data  <= fill_data;
            end
            if (flush) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign hit      = REUSE_EN && buf_valid && (buf_pc == lookup_pc) && !flush;
    assign hit_data = buf_data;

endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch stage with last-fetch reuse and request watchdog
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = PC_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = INSTR_BITS,
    parameter bit REUSE_EN              = 1'b1,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             flush,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_error
);

    localparam logic [WATCHDOG_BITS-1:0] TIMEOUT = WATCHDOG_BITS'(TIMEOUT_CYCLES);

    fetcher_state_t                   state, state_d;
    logic [WATCHDOG_BITS-1:0]         wd_cnt, wd_cnt_d;
    logic                             valid_d, error_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_d;
    logic                             start, hit, fill;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data;

    assign start = enable && (core_state == CORE_FETCH);
    assign fill  = (state == FS_FETCHING) && mem_read_ready;

    fetch_reuse_buf #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .REUSE_EN  (REUSE_EN)
    ) u_reuse_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .lookup_pc (current_pc),
        .fill      (fill),
        .fill_pc   (mem_read_address),
        .fill_data (mem_read_data),
        .hit       (hit),
        .hit_data  (hit_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            FS_IDLE:     if (start) state_d = hit ? FS_FETCHED : FS_FETCHING;
            FS_FETCHING: if (mem_read_ready) state_d = FS_FETCHED;
            FS_FETCHED:  if (core_state == CORE_DECODE) state_d = FS_IDLE;
            default:     state_d = FS_IDLE;
        endcase
    end

    // Next values for the registered outputs; everything holds unless a transition updates it.
    always_comb begin
        valid_d  = mem_read_valid;
        addr_d   = mem_read_address;
        instr_d  = instruction;
        wd_cnt_d = wd_cnt;
        error_d  = fetch_error;
        case (state)
            FS_IDLE: begin
                if (start) begin
                    if (hit) begin
                        instr_d = hit_data;
                    end else begin
                        valid_d  = 1'b1;
                        addr_d   = current_pc;
                        wd_cnt_d = '0;
                    end
                end
            end
            FS_FETCHING: begin
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                end else begin
                    if (wd_cnt != '1) wd_cnt_d = wd_cnt + 1'b1;
                    if (wd_cnt_d >= TIMEOUT) error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            wd_cnt           <= '0;
            fetch_error      <= 1'b0;
        end else begin
            mem_read_valid   <= valid_d;
            mem_read_address <= addr_d;
            instruction      <= instr_d;
            wd_cnt           <= wd_cnt_d;
            fetch_error      <= error_d;
        end
    end

    assign fetcher_state = state;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - directed self-checking bench for instr_fetcher
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        reset, enable, flush, mem_read_ready;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [15:0] mem_read_data;

    logic        a_valid, b_valid, a_err, b_err;
    logic [7:0]  a_addr, b_addr;
    logic [2:0]  a_state, b_state;
    logic [15:0] a_instr, b_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetcher #(.REUSE_EN(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .core_state(core_state), .current_pc(current_pc),
        .mem_read_valid(a_valid), .mem_read_address(a_addr),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(a_state), .instruction(a_instr), .fetch_error(a_err)
    );

    instr_fetcher #(.REUSE_EN(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .core_state(core_state), .current_pc(current_pc),
        .mem_read_valid(b_valid), .mem_read_address(b_addr),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(b_state), .instruction(b_instr), .fetch_error(b_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; flush = 1'b0; mem_read_ready = 1'b0;
        core_state = 3'b000; current_pc = 8'h00; mem_read_data = 16'h0000;
        @(negedge clk);
        tick(); tick();
        chk("rst_state", a_state, 3'b000);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_addr", a_addr, 8'h00);
        chk("rst_instr", a_instr, 16'h0000);
        chk("rst_err", a_err, 1'b0);
        reset = 1'b1;

        // reset during an outstanding request, late ready ignored
        enable = 1'b1; core_state = 3'b001; current_pc = 8'h33;
        tick();
        chk("pre_rst_valid", a_valid, 1'b1);
        chk("pre_rst_addr", a_addr, 8'h33);
        core_state = 3'b100; reset = 1'b0;
        tick(); tick();
        reset = 1'b1; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
        tick();
        mem_read_ready = 1'b0;
        chk("midrst_state", a_state, 3'b000);
        chk("midrst_valid", a_valid, 1'b0);
        chk("midrst_addr", a_addr, 8'h00);
        chk("midrst_instr", a_instr, 16'h0000);

        // miss on 8'h10, ready three cycles after the request appears
        core_state = 3'b001; current_pc = 8'h10;
        tick();
        chk("miss_state", a_state, 3'b001);
        chk("miss_valid", a_valid, 1'b1);
        chk("miss_addr", a_addr, 8'h10);
        core_state = 3'b100;
        tick();
        chk("miss_hold1_valid", a_valid, 1'b1);
        chk("miss_hold1_addr", a_addr, 8'h10);
        tick();
        chk("miss_hold2_valid", a_valid, 1'b1);
        chk("miss_hold2_addr", a_addr, 8'h10);
        mem_read_ready = 1'b1; mem_read_data = 16'hA5C3;
        tick();
        mem_read_ready = 1'b0;
        chk("miss_done_state", a_state, 3'b010);
        chk("miss_done_instr", a_instr, 16'hA5C3);
        chk("miss_done_valid", a_valid, 1'b0);
        chk("miss_done_err", a_err, 1'b0);
        tick();
        chk("fetched_hold_state", a_state, 3'b010);
        core_state = 3'b010;
        tick();
        chk("decode_idle_state", a_state, 3'b000);
        chk("decode_idle_instr", a_instr, 16'hA5C3);

        // hit on 8'h10; REUSE_EN=0 instance must still go to memory
        core_state = 3'b001; current_pc = 8'h10;
        tick();
        chk("hit_state", a_state, 3'b010);
        chk("hit_valid", a_valid, 1'b0);
        chk("hit_instr", a_instr, 16'hA5C3);
        chk("noreuse_state", b_state, 3'b001);
        chk("noreuse_valid", b_valid, 1'b1);
        chk("noreuse_addr", b_addr, 8'h10);
        core_state = 3'b010; mem_read_ready = 1'b1; mem_read_data = 16'hA5C3;
        tick();
        mem_read_ready = 1'b0;
        chk("late_ready_idle", a_state, 3'b000);
        chk("noreuse_done", b_state, 3'b010);
        tick();
        chk("noreuse_idle", b_state, 3'b000);

        // flush alongside a would-be hit forces a miss
        core_state = 3'b001; current_pc = 8'h10; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_miss_state", a_state, 3'b001);
        chk("flush_miss_valid", a_valid, 1'b1);
        core_state = 3'b100; mem_read_ready = 1'b1; mem_read_data = 16'h1234;
        tick();
        mem_read_ready = 1'b0;
        chk("flush_fill_instr", a_instr, 16'h1234);
        core_state = 3'b010;
        tick();
        core_state = 3'b001;
        tick();
        chk("refill_hit_state", a_state, 3'b010);
        chk("refill_hit_instr", a_instr, 16'h1234);
        core_state = 3'b010; mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        tick();
        chk("sync_a_idle", a_state, 3'b000);
        chk("sync_b_idle", b_state, 3'b000);

        // flush coincident with ready: data delivered, buffer left invalid
        core_state = 3'b001; current_pc = 8'h20;
        tick();
        core_state = 3'b100; mem_read_ready = 1'b1; flush = 1'b1; mem_read_data = 16'h5678;
        tick();
        mem_read_ready = 1'b0; flush = 1'b0;
        chk("flush_ready_state", a_state, 3'b010);
        chk("flush_ready_instr", a_instr, 16'h5678);
        core_state = 3'b010;
        tick();
        core_state = 3'b001;
        tick();
        chk("after_flush_miss_state", a_state, 3'b001);
        chk("after_flush_miss_valid", a_valid, 1'b1);
        chk("after_flush_miss_addr", a_addr, 8'h20);
        core_state = 3'b100; mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0; core_state = 3'b010;
        tick();

        // neighbouring PC misses
        core_state = 3'b001; current_pc = 8'h11;
        tick();
        chk("pc11_state", a_state, 3'b001);
        chk("pc11_addr", a_addr, 8'h11);
        core_state = 3'b100; mem_read_ready = 1'b1; mem_read_data = 16'h1111;
        tick();
        mem_read_ready = 1'b0;
        chk("pc11_instr", a_instr, 16'h1111);
        core_state = 3'b010;
        tick();

        // enable=0 blocks start
        enable = 1'b0; core_state = 3'b001; current_pc = 8'h44;
        tick(); tick();
        chk("disabled_state", a_state, 3'b000);
        chk("disabled_valid", a_valid, 1'b0);

        // dropping enable mid-request still completes
        enable = 1'b1;
        tick();
        chk("en_start_state", a_state, 3'b001);
        enable = 1'b0; core_state = 3'b100;
        tick();
        mem_read_ready = 1'b1; mem_read_data = 16'h4444;
        tick();
        mem_read_ready = 1'b0;
        chk("en_drop_state", a_state, 3'b010);
        chk("en_drop_instr", a_instr, 16'h4444);
        core_state = 3'b010;
        tick();
        chk("en_drop_idle", a_state, 3'b000);
        enable = 1'b1;

        // watchdog with TIMEOUT_CYCLES=4
        core_state = 3'b001; current_pc = 8'h55;
        tick();
        core_state = 3'b100;
        tick(); tick(); tick();
        chk("wd_3_err", a_err, 1'b0);
        tick();
        chk("wd_4_err", a_err, 1'b1);
        chk("wd_4_valid", a_valid, 1'b1);
        tick(); tick();
        chk("wd_6_err", a_err, 1'b1);
        chk("wd_6_state", a_state, 3'b001);
        mem_read_ready = 1'b1; mem_read_data = 16'h5555;
        tick();
        mem_read_ready = 1'b0;
        chk("wd_done_state", a_state, 3'b010);
        chk("wd_done_instr", a_instr, 16'h5555);
        chk("wd_sticky_err", a_err, 1'b1);
        core_state = 3'b010;
        tick();
        chk("wd_idle_err", a_err, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("wd_reset_err", a_err, 1'b0);
        chk("wd_reset_b_err", b_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
